// File: rtl/param_seq_processor_if.sv
// Instruction request / result bundle between an instruction source and param_seq_processor.
interface param_seq_processor_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
);
    logic                          start;
    logic [3+2*REG_ADDR_WIDTH-1:0] func;
    logic [DATA_WIDTH-1:0]         dataIn;
    logic [DATA_WIDTH-1:0]         dataOut;
    logic                          busy;
    logic                          done;
    logic                          carry;
    logic                          zero;

    modport master (output start, func, dataIn, input dataOut, busy, done, carry, zero);
    modport slave  (input start, func, dataIn, output dataOut, busy, done, carry, zero);
endinterface

// File: rtl/param_seq_processor.sv
// Multi-cycle register-file processor: one instruction per start/done handshake,
// with carry/zero flags, an iterative shift-add multiply and a registered output port.
module param_seq_processor #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input logic                  clock,
    input logic                  reset,
    param_seq_processor_if.slave bus
);
    localparam int W    = DATA_WIDTH;
    localparam int A    = REG_ADDR_WIDTH;
    localparam int NREG = 1 << A;
    localparam int FW   = 3 + 2 * A;
    localparam int CW   = $clog2(W + 1);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
    state_t state, stateNext;

    logic [FW-1:0]    funcReg;
    logic [W-1:0]     dataInReg;
    logic [W-1:0]     regFile [NREG];
    logic [W-1:0]     dataOutReg;
    logic             carryReg;
    logic             zeroReg;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [CW-1:0]    iter;

    logic [2:0]       opCode;
    logic [A-1:0]     rx;
    logic [A-1:0]     ry;
    logic [W-1:0]     opA;
    logic [W-1:0]     opB;
    logic [W:0]       sum;
    logic [W:0]       diff;
    logic [2*W-1:0]   accNext;
    logic [W-1:0]     aluRes;
    logic             aluCarry;
    logic             wrReg;
    logic             wrFlags;
    logic             wrOut;
    logic             capture;
    logic             execStep;
    logic             mulStep;
    logic             mulLast;

    assign opCode  = funcReg[FW-1 -: 3];
    assign rx      = funcReg[2*A-1 -: A];
    assign ry      = funcReg[A-1:0];
    assign opA     = regFile[rx];
    assign opB     = regFile[ry];
    assign sum     = {1'b0, opA} + {1'b0, opB};
    // Bit W of the extended difference is the borrow (set iff opA < opB).
    assign diff    = {1'b0, opA} - {1'b0, opB};
    assign accNext = mplier[0] ? acc + mcand : acc;
    assign mulLast = (iter == CW'(W - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (bus.start) stateNext = S_EXEC;
            S_EXEC:  stateNext = (opCode == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:   if (mulLast) stateNext = S_DONE;
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        capture  = 1'b0;
        execStep = 1'b0;
        mulStep  = 1'b0;
        bus.busy = 1'b1;
        bus.done = 1'b0;
        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                capture  = bus.start;
            end
            S_EXEC:  execStep = 1'b1;
            S_MUL:   mulStep  = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        aluRes   = opB;
        aluCarry = carryReg;
        wrReg    = 1'b0;
        wrFlags  = 1'b0;
        wrOut    = 1'b0;
        case (opCode)
            OP_LOAD: begin aluRes = dataInReg; wrReg = 1'b1; end
            OP_MOVE: begin aluRes = opB; wrReg = 1'b1; end
            OP_ADD:  begin aluRes = sum[W-1:0]; aluCarry = sum[W]; wrReg = 1'b1; wrFlags = 1'b1; end
            OP_SUB:  begin aluRes = diff[W-1:0]; aluCarry = diff[W]; wrReg = 1'b1; wrFlags = 1'b1; end
            OP_AND:  begin aluRes = opA & opB; aluCarry = 1'b0; wrReg = 1'b1; wrFlags = 1'b1; end
            OP_OUT:  wrOut = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            funcReg    <= '0;
            dataInReg  <= '0;
            dataOutReg <= '0;
            carryReg   <= 1'b0;
            zeroReg    <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            iter       <= '0;
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else begin
            if (capture) begin
                funcReg   <= bus.func;
                dataInReg <= bus.dataIn;
            end
            if (execStep) begin
                if (opCode == OP_MUL) begin
                    acc    <= '0;
                    mcand  <= {{W{1'b0}}, opA};
                    mplier <= opB;
                    iter   <= '0;
                end
                if (wrReg) regFile[rx] <= aluRes;
                if (wrFlags) begin
                    carryReg <= aluCarry;
                    zeroReg  <= (aluRes == '0);
                end
                if (wrOut) dataOutReg <= opA;
            end
            // Fixed W-iteration shift-add; the final step commits straight from accNext.
            if (mulStep) begin
                acc    <= accNext;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                iter   <= iter + CW'(1);
                if (mulLast) begin
                    regFile[rx] <= accNext[W-1:0];
                    carryReg    <= |accNext[2*W-1:W];
                    zeroReg     <= (accNext[W-1:0] == '0);
                end
            end
        end
    end

    assign bus.dataOut = dataOutReg;
    assign bus.carry   = carryReg;
    assign bus.zero    = zeroReg;
endmodule

// File: tb/tb_param_seq_processor.sv
// Scoreboard bench for param_seq_processor: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_param_seq_processor;
    localparam int W = 8;
    localparam int A = 3;
    localparam int M = 1 << W;

    logic clock = 1'b0;
    logic reset = 1'b1;

    param_seq_processor_if #(.DATA_WIDTH(W), .REG_ADDR_WIDTH(A)) bus();

    param_seq_processor #(.DATA_WIDTH(W), .REG_ADDR_WIDTH(A)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int dout;
        int c;
        int z;
        int issue;
        int lat;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleCount = 0;
    int   mreg[8];
    int   mc, mz, mout;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mreg[i] = 0;
        mc = 0; mz = 0; mout = 0;
    endtask

    function automatic exp_t modelStep(input int op, input int rx, input int ry, input int din);
        exp_t e;
        int a, b, r;
        a = mreg[rx];
        b = mreg[ry];
        case (op)
            0: mreg[rx] = din;
            1: mreg[rx] = b;
            2: begin r = a + b; mreg[rx] = r % M; mc = (r >= M) ? 1 : 0; mz = (r % M == 0) ? 1 : 0; end
            3: begin mreg[rx] = (a - b + M) % M; mc = (a < b) ? 1 : 0; mz = (a == b) ? 1 : 0; end
            4: begin mreg[rx] = a & b; mc = 0; mz = ((a & b) == 0) ? 1 : 0; end
            5: begin r = a * b; mreg[rx] = r % M; mc = (r >= M) ? 1 : 0; mz = (r % M == 0) ? 1 : 0; end
            6: mout = a;
            default: ;
        endcase
        e.dout  = mout;
        e.c     = mc;
        e.z     = mz;
        e.lat   = (op == 5) ? W + 2 : 2;
        e.issue = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pulse", cycleCount);
            end else begin
                monE = expQ.pop_front();
                check("dataOut", int'(bus.dataOut), monE.dout);
                check("carry", int'(bus.carry), monE.c);
                check("zero", int'(bus.zero), monE.z);
                check("done_latency", cycleCount - monE.issue, monE.lat);
            end
        end
    end

    task automatic runInstr(input int op, input int rx, input int ry, input int din, input bit noise);
        exp_t e;
        bit   got;
        @(negedge clock);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_done", int'(bus.done), 0);
        bus.start  = 1'b1;
        bus.func   = {3'(op), 3'(rx), 3'(ry)};
        bus.dataIn = 8'(din);
        e = modelStep(op, rx, ry, din);
        e.issue = cycleCount;
        expQ.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            if (k == 0) check("busy_cycle1", int'(bus.busy), 1);
            if (bus.done) begin
                got = 1'b1;
                check("busy_in_done", int'(bus.busy), 1);
            end
            if (noise) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.func   = {3'b010, 6'($urandom_range(0, 63))};
                bus.dataIn = 8'($urandom_range(0, 255));
            end else begin
                bus.start = 1'b0;
            end
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done within 40 cycles, expected done after %0d", e.lat);
        end
        if (noise) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
    endtask

    // Asserts reset between clock edges and checks that outputs clear without an edge.
    task automatic midReset(input int afterEdges);
        repeat (afterEdges) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_dataOut", int'(bus.dataOut), 0);
        check("rst_carry", int'(bus.carry), 0);
        check("rst_zero", int'(bus.zero), 0);
        expQ.delete();
        modelReset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time %0t, expected bench to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int doneCount;
        bus.start  = 1'b0;
        bus.func   = '0;
        bus.dataIn = '0;
        modelReset();
        #3;
        check("por_busy", int'(bus.busy), 0);
        check("por_dataOut", int'(bus.dataOut), 0);
        check("por_carry", int'(bus.carry), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        runInstr(0, 1, 0, 200, 1'b0);
        runInstr(0, 2, 0, 100, 1'b0);
        runInstr(2, 1, 2, 0, 1'b0);
        runInstr(6, 1, 0, 0, 1'b0);

        midReset(1);
        for (int r = 0; r < 8; r++) runInstr(6, r, 0, 0, 1'b0);

        runInstr(0, 2, 0, 100, 1'b0);
        runInstr(3, 2, 2, 0, 1'b0);
        runInstr(0, 3, 0, 5, 1'b0);
        runInstr(0, 4, 0, 9, 1'b0);
        runInstr(3, 3, 4, 0, 1'b0);
        runInstr(6, 3, 0, 0, 1'b0);

        runInstr(0, 5, 0, 13, 1'b0);
        runInstr(0, 6, 0, 11, 1'b0);
        runInstr(5, 5, 6, 0, 1'b0);
        runInstr(6, 5, 0, 0, 1'b0);
        runInstr(0, 7, 0, 20, 1'b0);
        runInstr(5, 7, 7, 0, 1'b0);
        runInstr(6, 7, 0, 0, 1'b0);
        runInstr(5, 5, 0, 0, 1'b0);
        runInstr(4, 3, 4, 0, 1'b0);
        runInstr(1, 1, 3, 0, 1'b0);
        runInstr(7, 1, 1, 0, 1'b0);
        runInstr(6, 1, 0, 0, 1'b0);

        runInstr(0, 1, 0, 10, 1'b0);
        runInstr(0, 2, 0, 20, 1'b0);
        runInstr(2, 1, 2, 0, 1'b1);
        runInstr(6, 1, 0, 0, 1'b0);
        runInstr(5, 1, 2, 0, 1'b1);
        runInstr(6, 1, 0, 0, 1'b0);

        runInstr(0, 5, 0, 13, 1'b0);
        runInstr(0, 6, 0, 11, 1'b0);
        @(negedge clock);
        bus.start = 1'b1;
        bus.func  = {3'd5, 3'd5, 3'd6};
        @(negedge clock);
        bus.start = 1'b0;
        midReset(5);
        doneCount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.done) doneCount++;
        end
        check("no_done_after_rst", doneCount, 0);
        runInstr(6, 5, 0, 0, 1'b0);
        runInstr(0, 5, 0, 42, 1'b0);
        runInstr(6, 5, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            runInstr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
        end
        for (int r = 0; r < 8; r++) runInstr(6, r, 0, 0, 1'b0);

        repeat (5) @(negedge clock);
        check("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
